// File: rtl/nexys4_io_bridge.sv
// -----------------------------------------------------------------------------
// nexys4_io_bridge
//
// KCPSM6 port-mapped I/O bridge for the Nexys4 designs. It holds the
// seven-segment digit registers and a double-buffered RGB colour word. It also
// captures live buttons and latches their rising edges. A programmable
// millisecond tick and a two-state interrupt controller complete the block.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   db_btns           debounced buttons, active-high
//   digits            digit i in bits [i*DIG_W +: DIG_W]
//   rgb               committed colour {red, green, blue}
//   port_id           KCPSM6 port address (read and write)
//   out_port          KCPSM6 write data
//   in_port           KCPSM6 read data, registered (1-cycle latency)
//   write_strobe,
//   k_write_strobe    write qualifiers, treated identically
//   read_strobe       read qualifier (only used to clear the edge latch)
//   interrupt_ack     KCPSM6 interrupt acknowledge
//   interrupt         interrupt request, registered
// -----------------------------------------------------------------------------
module nexys4_io_bridge #(
  parameter int         CLK_HZ          = 100_000_000,
  parameter int         NUM_DIGITS      = 8,
  parameter int         DIG_W           = 5,
  parameter int         COLOR_W         = 4,
  parameter int         NUM_BTNS        = 6,
  parameter int         TICK_MS_DEFAULT = 500,
  parameter logic [7:0] PA_BTNS         = 8'h00,
  parameter logic [7:0] PA_BTN_EDGE     = 8'h01,
  parameter logic [7:0] PA_INT_CAUSE    = 8'h02,
  parameter logic [7:0] PA_INT_EN       = 8'h03,
  parameter logic [7:0] PA_TICK_LO      = 8'h04,
  parameter logic [7:0] PA_TICK_HI      = 8'h05,
  parameter logic [7:0] PA_RED          = 8'h08,
  parameter logic [7:0] PA_GREEN        = 8'h09,
  parameter logic [7:0] PA_BLUE         = 8'h0A,
  parameter logic [7:0] PA_RGB_COMMIT   = 8'h0B,
  parameter logic [7:0] PA_DIG_BASE     = 8'h10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_BTNS-1:0]          db_btns,
  output logic [NUM_DIGITS*DIG_W-1:0]  digits,
  output logic [3*COLOR_W-1:0]         rgb,
  input  logic [7:0]                   port_id,
  input  logic [7:0]                   out_port,
  output logic [7:0]                   in_port,
  input  logic                         write_strobe,
  input  logic                         k_write_strobe,
  input  logic                         read_strobe,
  input  logic                         interrupt_ack,
  output logic                         interrupt
);

  // Prescaler divide ratio for a 1 ms pulse; a 1-bit counter covers DIV==1.
  localparam int DIV   = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [DIG_W-1:0]     digits_q [NUM_DIGITS];
  logic [DIG_W-1:0]     digits_d [NUM_DIGITS];
  logic [COLOR_W-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic [7:0]           stage_q, stage_d;
  logic [15:0]          period_q, period_d;
  logic [15:0]          ms_q, ms_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [1:0]           int_en_q, int_en_d;
  logic [1:0]           status_q, status_d;
  logic [1:0]           cause_q, cause_d;
  logic [NUM_BTNS-1:0]  btn_prev_q;
  logic [NUM_BTNS-1:0]  edge_q, edge_d;
  logic [7:0]           in_port_q, in_port_d;
  irq_state_e           state_q, state_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic             wr_en;
  logic [7:0]       dig_off;
  logic             dig_hit;
  logic [IDX_W-1:0] dig_idx;
  logic             tick_restart;
  logic             ms_pulse;
  logic             tick;
  logic [NUM_BTNS-1:0] btn_rise;
  logic             edge_clr;
  logic [1:0]       pending;
  logic             ack_take;

  assign wr_en        = write_strobe | k_write_strobe;
  assign dig_off      = port_id - PA_DIG_BASE;
  assign dig_hit      = (port_id >= PA_DIG_BASE) && (dig_off < 8'(NUM_DIGITS));
  assign dig_idx      = dig_off[IDX_W-1:0];
  assign tick_restart = wr_en && (port_id == PA_TICK_HI);

  assign btn_rise = db_btns & ~btn_prev_q;
  assign edge_clr = read_strobe && (port_id == PA_BTN_EDGE);
  assign pending  = status_q & int_en_q;
  assign ack_take = (state_q == IRQ_REQ) && interrupt_ack;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that leaves a
  // variable unassigned would infer a latch.
  always_comb begin
    digits_d = digits_q;
    red_d    = red_q;
    green_d  = green_q;
    blue_d   = blue_q;
    rgb_d    = rgb_q;
    stage_d  = stage_q;
    period_d = period_q;
    int_en_d = int_en_q;
    if (wr_en) begin
      case (port_id)
        PA_RED:        red_d    = out_port[COLOR_W-1:0];
        PA_GREEN:      green_d  = out_port[COLOR_W-1:0];
        PA_BLUE:       blue_d   = out_port[COLOR_W-1:0];
        // All three components switch on the same edge, so the image
        // controller never sees a half-updated colour.
        PA_RGB_COMMIT: rgb_d    = {red_q, green_q, blue_q};
        PA_TICK_LO:    stage_d  = out_port;
        PA_TICK_HI:    period_d = {out_port, stage_q};
        PA_INT_EN:     int_en_d = out_port[1:0];
        default: begin
          if (dig_hit) digits_d[dig_idx] = out_port[DIG_W-1:0];
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Millisecond tick
  // ---------------------------------------------------------------------------
  assign ms_pulse = (pre_q == PRE_W'(DIV - 1));
  // A TICK_HI write restarts the period, so it also swallows a coinciding tick.
  assign tick     = !tick_restart && (period_q != 16'd0) && ms_pulse &&
                    (ms_q == period_q - 16'd1);

  always_comb begin
    pre_d = pre_q;
    ms_d  = ms_q;
    if (tick_restart) begin
      pre_d = '0;
      ms_d  = '0;
    end else begin
      pre_d = ms_pulse ? '0 : pre_q + 1'b1;
      if (period_q == 16'd0) begin
        ms_d = '0;
      end else if (ms_pulse) begin
        ms_d = (ms_q == period_q - 16'd1) ? 16'd0 : ms_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge latch, status and cause
  // ---------------------------------------------------------------------------
  always_comb begin
    // Set wins over the read-clear so an edge landing on the read is kept.
    edge_d   = (edge_clr ? '0 : edge_q) | btn_rise;
    // Only bits handed over in cause are cleared; events arriving in the ack
    // cycle are OR-ed back in and raise a fresh request.
    status_d = (status_q & ~(ack_take ? pending : 2'b00)) | {|btn_rise, tick};
    cause_d  = ack_take ? pending : cause_q;
  end

  // ---------------------------------------------------------------------------
  // Read mux; sampled every cycle regardless of read_strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    in_port_d = 8'h00;
    case (port_id)
      PA_BTNS:      in_port_d = 8'(db_btns);
      PA_BTN_EDGE:  in_port_d = 8'(edge_q);
      PA_INT_CAUSE: in_port_d = {6'b0, cause_q};
      PA_INT_EN:    in_port_d = {6'b0, int_en_q};
      PA_TICK_LO:   in_port_d = period_q[7:0];
      PA_TICK_HI:   in_port_d = period_q[15:8];
      PA_RED:       in_port_d = 8'(red_q);
      PA_GREEN:     in_port_d = 8'(green_q);
      PA_BLUE:      in_port_d = 8'(blue_q);
      default: begin
        if (dig_hit) in_port_d = 8'(digits_q[dig_idx]);
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the digit array is a bank of flops, not a RAM, so it is reset
      // like any other register.
      digits_q   <= '{default: '0};
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      rgb_q      <= '0;
      stage_q    <= '0;
      period_q   <= 16'(TICK_MS_DEFAULT);
      ms_q       <= '0;
      pre_q      <= '0;
      int_en_q   <= '0;
      status_q   <= '0;
      cause_q    <= '0;
      btn_prev_q <= '0;
      edge_q     <= '0;
      in_port_q  <= '0;
    end else begin
      digits_q   <= digits_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      rgb_q      <= rgb_d;
      stage_q    <= stage_d;
      period_q   <= period_d;
      ms_q       <= ms_d;
      pre_q      <= pre_d;
      int_en_q   <= int_en_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      btn_prev_q <= db_btns;
      edge_q     <= edge_d;
      in_port_q  <= in_port_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IRQ_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE: if (pending != 2'b00) state_d = IRQ_REQ;
      IRQ_REQ:  if (interrupt_ack)    state_d = IRQ_IDLE;
      default:                        state_d = IRQ_IDLE;
    endcase
  end

  // The state is a single flop, so the request comes straight from a register.
  always_comb begin
    interrupt = (state_q == IRQ_REQ);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digits
    assign digits[i*DIG_W +: DIG_W] = digits_q[i];
  end

  assign rgb     = rgb_q;
  assign in_port = in_port_q;

endmodule
